// File: rtl/bp_mem_burst_to_lite_conv_pkg.sv
// Shared definitions for the burst-to-lite memory message converter.
//   - memory message type and size-code enumerations
//   - header field offsets / widths
//   - default payload mask (which msg_types carry data beats)
//   - converter FSM state encoding
//   - helper computing the number of data beats a header announces
package bp_mem_burst_to_lite_conv_pkg;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'd0,
        e_mem_msg_wr    = 4'd1,
        e_mem_msg_uc_rd = 4'd2,
        e_mem_msg_uc_wr = 4'd3
    } bp_mem_msg_e;

    // Size code n means 2^n bytes
    typedef enum logic [2:0] {
        e_mem_size_1  = 3'd0,
        e_mem_size_2  = 3'd1,
        e_mem_size_4  = 3'd2,
        e_mem_size_8  = 3'd3,
        e_mem_size_16 = 3'd4,
        e_mem_size_32 = 3'd5,
        e_mem_size_64 = 3'd6
    } bp_mem_size_e;

    localparam int unsigned mem_msg_type_offset_gp = 0;
    localparam int unsigned mem_msg_type_width_gp  = 4;
    localparam int unsigned mem_size_offset_gp     = 4;
    localparam int unsigned mem_size_width_gp      = 3;

    // Only writes carry data on the command path by default
    localparam logic [15:0] mem_payload_mask_gp = 16'h0002;

    typedef enum logic [1:0] {
        e_conv_idle = 2'd0,
        e_conv_data = 2'd1,
        e_conv_out  = 2'd2
    } conv_state_e;

    // Beats following a header: zero for header-only types, otherwise the
    // message size in beats, at least one and at most max_beats.
    function automatic int unsigned mem_beats(
        input logic [mem_msg_type_width_gp-1:0] msg_type,
        input logic [mem_size_width_gp-1:0]     size,
        input logic [15:0]                      mask,
        input int unsigned                      in_width,
        input int unsigned                      max_beats
    );
        int unsigned bits;
        int unsigned beats;
        bits  = 32'd8 << size;
        beats = bits / in_width;
        if (beats == 0)
            beats = 1;
        if (beats > max_beats)
            beats = max_beats;
        if (!mask[msg_type])
            beats = 0;
        return beats;
    endfunction

endpackage

// File: rtl/bp_mem_burst_to_lite_conv_sipo.sv
// Serial-in / parallel-out beat collector.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : new message; clears counter/data and loads beat target
//   beats_i        : number of beats in the new message (0 = header only)
//   beat_v_i       : a beat is transferring this cycle
//   beat_i         : beat data
//   last_o         : the transferring beat is the final one
//   data_o         : assembled data, short messages replicated to full width
module bp_mem_sipo_collector #(
    parameter int unsigned in_data_width_p  = 64,
    parameter int unsigned out_data_width_p = 512,
    parameter int unsigned cnt_width_p      = $clog2(out_data_width_p / in_data_width_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [cnt_width_p-1:0]      beats_i,
    input  logic                        beat_v_i,
    input  logic [in_data_width_p-1:0]  beat_i,
    output logic                        last_o,
    output logic [out_data_width_p-1:0] data_o
);

    localparam int unsigned max_beats_lp = out_data_width_p / in_data_width_p;

    logic [cnt_width_p-1:0]      cnt_r;
    logic [cnt_width_p-1:0]      beats_r;
    logic [out_data_width_p-1:0] data_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r   <= '0;
            beats_r <= '0;
            data_r  <= '0;
        end else if (start_i) begin
            cnt_r   <= '0;
            beats_r <= beats_i;
            data_r  <= '0;
        end else if (beat_v_i) begin
            data_r[32'(cnt_r)*in_data_width_p +: in_data_width_p] <= beat_i;
            cnt_r <= cnt_r + cnt_width_p'(1);
        end
    end

    assign last_o = beat_v_i && (cnt_r == beats_r - cnt_width_p'(1));

    // Beat counts are powers of two, so output chunk c mirrors collected
    // chunk (c mod beats); a full-size message maps straight through.
    always_comb begin
        data_o = '0;
        if (beats_r != '0) begin
            for (int unsigned c = 0; c < max_beats_lp; c++) begin
                data_o[c*in_data_width_p +: in_data_width_p] =
                    data_r[(c & (32'(beats_r) - 1))*in_data_width_p +: in_data_width_p];
            end
        end
    end

endmodule

// File: rtl/bp_mem_burst_to_lite_conv.sv
// Burst-to-lite memory message converter: accepts a header followed by
// zero or more narrow data beats and emits one {data, header} message.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   mem_header_i/_v_i       : burst header in, ready via mem_header_ready_and_o
//   mem_data_i/_v_i         : data beats in, ready via mem_data_ready_and_o
//   mem_o/mem_v_o           : lite message out {data, header}, header in LSBs
//   mem_ready_and_i         : downstream ready
module bp_mem_burst_to_lite_conv
    import bp_mem_burst_to_lite_conv_pkg::*;
#(
    parameter int unsigned in_data_width_p  = 64,
    parameter int unsigned out_data_width_p = 512,
    parameter int unsigned header_width_p   = 64,
    parameter logic [15:0] payload_mask_p   = mem_payload_mask_gp
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [header_width_p-1:0]                  mem_header_i,
    input  logic                                       mem_header_v_i,
    output logic                                       mem_header_ready_and_o,
    input  logic [in_data_width_p-1:0]                 mem_data_i,
    input  logic                                       mem_data_v_i,
    output logic                                       mem_data_ready_and_o,
    output logic [header_width_p+out_data_width_p-1:0] mem_o,
    output logic                                       mem_v_o,
    input  logic                                       mem_ready_and_i
);

    localparam int unsigned max_beats_lp = out_data_width_p / in_data_width_p;
    localparam int unsigned cnt_width_lp = $clog2(max_beats_lp + 1);

    conv_state_e                 state_r, state_n;
    logic [header_width_p-1:0]   header_r;
    logic [cnt_width_lp-1:0]     beats_n;
    logic [out_data_width_p-1:0] data_lo;
    logic                        last_lo;
    logic                        header_xfer, data_xfer;

    assign header_xfer = mem_header_v_i & mem_header_ready_and_o;
    assign data_xfer   = mem_data_v_i & mem_data_ready_and_o;

    assign beats_n = cnt_width_lp'(mem_beats(
        mem_header_i[mem_msg_type_offset_gp +: mem_msg_type_width_gp],
        mem_header_i[mem_size_offset_gp +: mem_size_width_gp],
        payload_mask_p, in_data_width_p, max_beats_lp));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= e_conv_idle;
            header_r <= '0;
        end else begin
            state_r <= state_n;
            if (header_xfer)
                header_r <= mem_header_i;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_conv_idle: if (header_xfer)
                             state_n = (beats_n != '0) ? e_conv_data : e_conv_out;
            e_conv_data: if (last_lo)
                             state_n = e_conv_out;
            e_conv_out:  if (mem_ready_and_i)
                             state_n = e_conv_idle;
            default:     state_n = e_conv_idle;
        endcase
    end

    // Gated by reset so nothing handshakes during the reset cycle itself
    always_comb begin
        mem_header_ready_and_o = 1'b0;
        mem_data_ready_and_o   = 1'b0;
        mem_v_o                = 1'b0;
        if (!reset_i) begin
            mem_header_ready_and_o = (state_r == e_conv_idle);
            mem_data_ready_and_o   = (state_r == e_conv_data);
            mem_v_o                = (state_r == e_conv_out);
        end
    end

    bp_mem_sipo_collector #(
        .in_data_width_p (in_data_width_p),
        .out_data_width_p(out_data_width_p),
        .cnt_width_p     (cnt_width_lp)
    ) collector (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (header_xfer),
        .beats_i (beats_n),
        .beat_v_i(data_xfer),
        .beat_i  (mem_data_i),
        .last_o  (last_lo),
        .data_o  (data_lo)
    );

    assign mem_o = {data_lo, header_r};

endmodule

// File: tb/tb_bp_mem_burst_to_lite_conv.sv
module tb_bp_mem_burst_to_lite_conv;

    localparam int unsigned IW = 64;
    localparam int unsigned OW = 512;
    localparam int unsigned HW = 64;
    localparam int unsigned MW = HW + OW;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [HW-1:0] mem_header_i;
    logic          mem_header_v_i;
    logic          mem_header_ready_and_o;
    logic [IW-1:0] mem_data_i;
    logic          mem_data_v_i;
    logic          mem_data_ready_and_o;
    logic [MW-1:0] mem_o;
    logic          mem_v_o;
    logic          mem_ready_and_i;

    always #5 clk = ~clk;

    bp_mem_burst_to_lite_conv #(
        .in_data_width_p (IW),
        .out_data_width_p(OW),
        .header_width_p  (HW),
        .payload_mask_p  (16'h0002)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .mem_header_i          (mem_header_i),
        .mem_header_v_i        (mem_header_v_i),
        .mem_header_ready_and_o(mem_header_ready_and_o),
        .mem_data_i            (mem_data_i),
        .mem_data_v_i          (mem_data_v_i),
        .mem_data_ready_and_o  (mem_data_ready_and_o),
        .mem_o                 (mem_o),
        .mem_v_o               (mem_v_o),
        .mem_ready_and_i       (mem_ready_and_i)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_fails  = 0;
    int            cyc = 0;
    int            hdr_cyc = 0, v_rise_cyc = 0, out_cyc = 0;
    logic          v_prev = 1'b0;
    logic          data_rdy_seen = 1'b0;
    logic [MW-1:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s", name);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mem_v_o && mem_ready_and_i) begin
            out_cyc = cyc;
            if (exp_q.size() == 0)
                fail_now("unexpected_output");
            else
                check("lite_msg", mem_o, exp_q.pop_front());
        end
        if (mem_v_o && !v_prev)
            v_rise_cyc = cyc;
        v_prev = mem_v_o;
        if (mem_header_v_i && mem_header_ready_and_o)
            hdr_cyc = cyc;
        if (mem_data_ready_and_o)
            data_rdy_seen = 1'b1;
    end

    task automatic send_header(input logic [HW-1:0] h);
        bit done = 0;
        mem_header_i   = h;
        mem_header_v_i = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (mem_header_ready_and_o) begin
                check("data_rdy_with_header", MW'(mem_data_ready_and_o), MW'(0));
                @(posedge clk); #1;
                done = 1;
            end
        end
        if (!done) fail_now("header_accept_timeout");
        mem_header_v_i = 1'b0;
    endtask

    task automatic send_beat(input logic [IW-1:0] d);
        bit done = 0;
        mem_data_i   = d;
        mem_data_v_i = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (mem_data_ready_and_o) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        if (!done) fail_now("beat_accept_timeout");
        mem_data_v_i = 1'b0;
        mem_data_i   = '1;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mem_v_o) done = 1;
        end
        if (!done) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    logic [OW-1:0] d_exp;
    logic [MW-1:0] held;
    logic [HW-1:0] h;

    initial begin
        reset_i         = 1'b1;
        mem_header_i    = '0;
        mem_header_v_i  = 1'b0;
        mem_data_i      = '0;
        mem_data_v_i    = 1'b0;
        mem_ready_and_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_ready", MW'(mem_header_ready_and_o), MW'(0));
        check("rst_data_ready", MW'(mem_data_ready_and_o), MW'(0));
        check("rst_v", MW'(mem_v_o), MW'(0));
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("idle_hdr_ready", MW'(mem_header_ready_and_o), MW'(1));
        check("idle_v", MW'(mem_v_o), MW'(0));
        @(posedge clk); #1;

        // Full 8-beat write, size 64B
        h = 64'h0000_1234_5678_0061;
        for (int unsigned i = 0; i < 8; i++) d_exp[i*64 +: 64] = 64'(i);
        exp_q.push_back({d_exp, h});
        send_header(h);
        for (int unsigned i = 0; i < 8; i++) send_beat(64'(i));
        wait_idle();
        check("latency_8beat", MW'(v_rise_cyc - hdr_cyc), MW'(9));

        // One-beat write, size 8B, replicated
        h = 64'h0000_ABCD_0000_0031;
        exp_q.push_back({{8{64'hDEADBEEF_01234567}}, h});
        send_header(h);
        send_beat(64'hDEADBEEF_01234567);
        @(negedge clk);
        check("data_rdy_after_last", MW'(mem_data_ready_and_o), MW'(0));
        wait_idle();
        check("latency_1beat", MW'(v_rise_cyc - hdr_cyc), MW'(2));

        // Header-only read
        h = 64'h0000_0000_0BAD_0060;
        data_rdy_seen = 1'b0;
        exp_q.push_back({{OW{1'b0}}, h});
        send_header(h);
        wait_idle();
        check("latency_read", MW'(v_rise_cyc - hdr_cyc), MW'(1));
        check("read_no_data_rdy", MW'(data_rdy_seen), MW'(0));

        // Backpressure in OUT
        mem_ready_and_i = 1'b0;
        h = 64'h0000_00FF_0000_0131;
        exp_q.push_back({{8{64'h0123_4567_89AB_CDEF}}, h});
        send_header(h);
        send_beat(64'h0123_4567_89AB_CDEF);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (mem_v_o) seen = 1;
            end
            if (!seen) fail_now("bp_valid_timeout");
        end
        held = mem_o;
        check("bp_msg_value", held, {{8{64'h0123_4567_89AB_CDEF}}, h});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stable", mem_o, held);
            check("bp_hdr_ready", MW'(mem_header_ready_and_o), MW'(0));
            check("bp_v", MW'(mem_v_o), MW'(1));
        end
        @(posedge clk); #1;
        mem_ready_and_i = 1'b1;
        h = 64'h0000_0000_0777_0060;
        exp_q.push_back({{OW{1'b0}}, h});
        send_header(h);
        check("hdr_after_release", MW'(hdr_cyc - out_cyc), MW'(1));
        wait_idle();

        // Beat gaps: valid toggles 1/0
        h = 64'h0000_5555_0000_0061;
        for (int unsigned i = 0; i < 8; i++) d_exp[i*64 +: 64] = 64'hB0B0_0000_0000_0000 | 64'(i);
        exp_q.push_back({d_exp, h});
        send_header(h);
        for (int unsigned i = 0; i < 8; i++) begin
            send_beat(64'hB0B0_0000_0000_0000 | 64'(i));
            @(posedge clk); #1;
        end
        wait_idle();

        // Reset after 3 of 8 beats: no output for the partial message
        send_header(64'h0000_9999_0000_0061);
        for (int unsigned i = 0; i < 3; i++) send_beat(64'hFFFF_0000_0000_0000 | 64'(i));
        reset_i = 1'b1;
        @(negedge clk);
        check("midrst_hdr_ready", MW'(mem_header_ready_and_o), MW'(0));
        check("midrst_data_ready", MW'(mem_data_ready_and_o), MW'(0));
        check("midrst_v", MW'(mem_v_o), MW'(0));
        @(posedge clk); #1;
        reset_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst_no_v", MW'(mem_v_o), MW'(0));
        @(posedge clk); #1;

        h = 64'h0000_7777_0000_0061;
        for (int unsigned i = 0; i < 8; i++) d_exp[i*64 +: 64] = 64'hC0C0_0000_0000_0000 | 64'(i);
        exp_q.push_back({d_exp, h});
        send_header(h);
        for (int unsigned i = 0; i < 8; i++) send_beat(64'hC0C0_0000_0000_0000 | 64'(i));
        wait_idle();
        check("latency_after_rst", MW'(v_rise_cyc - hdr_cyc), MW'(9));

        check("queue_drained", MW'(exp_q.size()), MW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/bp_mem_burst_to_lite_conv.md
Name: bp_mem_burst_to_lite_conv

Overview:
- Converts a burst-format memory message into a single lite-format message.
- Burst format: a header plus zero or more narrow data beats. Lite format: header plus one wide data field.
- Sits between the core's burst memory command port and a lite memory model or controller, on the command path (e.g. 64-bit beats into a 512-bit cache-block message).

Parameters:
- in_data_width_p, 64, width of one burst data beat; must divide out_data_width_p.
- out_data_width_p, 512, width of the lite data field; out_data_width_p/in_data_width_p = max beats (8).
- header_width_p, 64, width of the message header.
- payload_mask_p, 16'h0002, bit k set means msg_type k carries data beats.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- mem_header_i  in  header_width_p  burst header; [3:0] msg_type, [6:4] size code, upper bits address/opaque
- mem_header_v_i  in  1  header valid
- mem_header_ready_and_o  out  1  header ready
- mem_data_i  in  in_data_width_p  data beat
- mem_data_v_i  in  1  beat valid
- mem_data_ready_and_o  out  1  beat ready
- mem_o  out  header_width_p+out_data_width_p  lite message; {data, header}, header in LSBs
- mem_v_o  out  1  lite message valid
- mem_ready_and_i  in  1  downstream ready

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high.
- Handshakes are ready-and-valid: a transfer occurs when valid & ready are both high on a rising clock edge.
- FSM states:
  - IDLE: mem_header_ready_and_o=1. On header transfer, latch the header, clear the beat counter, and compute beats = payload_mask_p[msg_type] ? max(1, (8<<size)/in_data_width_p) : 0. Go to DATA if beats>0, else OUT.
  - DATA: mem_data_ready_and_o=1. Each beat transfer writes beat i into slice [i*in_data_width_p +: in_data_width_p] of the data register (beat 0 in the LSBs) and increments i. After the last beat, go to OUT.
  - OUT: mem_v_o=1. mem_o is stable and is the registered header plus assembled data. On mem_ready_and_i, go to IDLE.
- Ready outputs are 0 outside their own state. Data presented together with a header is not accepted until the next cycle (DATA state).
- Data formatting:
  - If the message size is smaller than out_data_width_p, the low 8<<size bits (minimum in_data_width_p) are replicated to fill the full data field.
  - Header-only messages output data = 0.
- Latency: with all valids high and no backpressure, a header in cycle 0 plus N beats in cycles 1..N gives mem_v_o in cycle N+1. A header-only message gives mem_v_o in cycle 1.
- Size codes yielding more than the max beats are clamped to the max beats.
- Reset:
  - State goes to IDLE; counter and data register are cleared; mem_v_o=0.
  - All ready outputs are 0 while reset_i is high.
  - Reset mid-burst discards the partial message; no output is produced for it.
- Throughput: one message per N+2 cycles; bubbles are acceptable.

Decomposition:
- Shared package:
  - msg_type enumeration (0 read, 1 write, 2 uncached read, 3 uncached write).
  - Header field offsets and widths.
  - Size-code enumeration (0..6 = 1..64 bytes).
  - Default payload mask constant.
- Sub-module: one natural sub-module, bp_mem_sipo_collector. It holds the beat counter and data register, performs the slice write, and generates done.

Test Plan:
- Write, size 6, 8 beats 64'h0..7 → one mem_v_o, 9 cycles after the header; data[64*i+:64]=i; header in mem_o[63:0] equals the input header.
- Write, size 3, one beat 64'hDEADBEEF_01234567 → data = that value replicated 8×; mem_data_ready_and_o drops after the one beat.
- Read, size 6, no beats → mem_v_o in the next cycle; data field = 0; mem_data_ready_and_o never asserted.
- Backpressure: mem_ready_and_i=0 for 5 cycles in OUT → mem_o constant and mem_header_ready_and_o=0; released on ready=1, and the next header is accepted the following cycle.
- Beat gaps: mem_data_v_i toggling 1/0 over an 8-beat write → beats packed in order with no loss or duplication.
- Reset after 3 of 8 beats → no output; the next write completes correctly with fresh data.
